// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: side selectors and gray/binary conversion.
// Helpers work at a fixed maximum width; callers zero-extend in and cast the result back down.
package fifo_pkg;

  localparam int FIFO_SIDE_RD = 0;
  localparam int FIFO_SIDE_WR = 1;
  localparam int GRAY_MAX_W   = 32;

  function automatic logic [GRAY_MAX_W-1:0] binary2Gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended upper bits stay zero, so narrower pointers convert correctly.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync_2ff.sv
// Two-flop synchronizer for the remote gray pointer. This is the only clock-domain
// crossing in the FIFO pointer logic; nothing may sit between the two stages.
module ptr_sync_2ff #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             hardReset_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  always_ff @(posedge clk or negedge hardReset_n) begin
    if (!hardReset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else if (flush) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= d;
      r_sync2 <= r_sync1;
    end
  end

  assign q = r_sync2;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Pointer/status controller for one side of the async FIFO: local binary pointer,
// synchronized remote pointer, registered empty/full stall, fill level, almost and sticky error.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRWIDTH = 6,
  parameter int SIDE      = 0,
  parameter int ALMOST_TH = 2
) (
  input  logic                 clk,
  input  logic                 hardReset_n,
  input  logic                 flush,
  input  logic                 rdWrEn,
  input  logic [ADDRWIDTH:0]   remoteAddrGray,
  output logic [ADDRWIDTH:0]   fifoAddr,
  output logic [ADDRWIDTH-1:0] memAddr,
  output logic                 rdWrDisable,
  output logic [ADDRWIDTH:0]   fifoLevel,
  output logic                 almostFlag,
  output logic                 overUnderErr
);

  localparam int             PW       = ADDRWIDTH + 1;
  localparam logic [PW-1:0]  DEPTH    = PW'(2**ADDRWIDTH);
  localparam logic [PW-1:0]  TH_LO    = PW'(ALMOST_TH);
  localparam logic [PW-1:0]  TH_HI    = PW'(2**ADDRWIDTH - ALMOST_TH);
  localparam logic           RST_FLAG = (SIDE == FIFO_SIDE_RD);

  logic [PW-1:0] r_addr;
  logic [PW-1:0] r_level;
  logic          r_dis;
  logic          r_almost;
  logic          r_err;

  logic [PW-1:0] w_remote_gray;
  logic [PW-1:0] w_remote_bin;
  logic          w_inc;
  logic [PW-1:0] w_addr_nxt;
  logic [PW-1:0] w_lvl;
  logic          w_dis_nxt;
  logic          w_almost_nxt;

  ptr_sync_2ff #(.WIDTH(PW)) u_cdc_remote_sync (
    .clk         (clk),
    .hardReset_n (hardReset_n),
    .flush       (flush),
    .d           (remoteAddrGray),
    .q           (w_remote_gray)
  );

  assign w_remote_bin = PW'(gray2bin(GRAY_MAX_W'(w_remote_gray)));
  assign w_inc        = rdWrEn & ~r_dis;
  assign w_addr_nxt   = r_addr + PW'(w_inc);

  // Status uses the next local pointer so a local op stalls with zero latency.
  always_comb begin
    w_lvl        = '0;
    w_dis_nxt    = RST_FLAG;
    w_almost_nxt = RST_FLAG;
    if (SIDE == FIFO_SIDE_RD) begin
      w_lvl        = w_remote_bin - w_addr_nxt;
      w_dis_nxt    = (w_lvl == '0);
      w_almost_nxt = (w_lvl <= TH_LO);
    end else begin
      w_lvl        = w_addr_nxt - w_remote_bin;
      w_dis_nxt    = (w_lvl == DEPTH);
      w_almost_nxt = (w_lvl >= TH_HI);
    end
  end

  always_ff @(posedge clk or negedge hardReset_n) begin
    if (!hardReset_n) begin
      r_addr   <= '0;
      r_level  <= '0;
      r_dis    <= RST_FLAG;
      r_almost <= RST_FLAG;
      r_err    <= 1'b0;
    end else if (flush) begin
      r_addr   <= '0;
      r_level  <= '0;
      r_dis    <= RST_FLAG;
      r_almost <= RST_FLAG;
      r_err    <= 1'b0;
    end else begin
      r_addr   <= w_addr_nxt;
      r_level  <= w_lvl;
      r_dis    <= w_dis_nxt;
      r_almost <= w_almost_nxt;
      if (rdWrEn && r_dis)
        r_err <= 1'b1;
    end
  end

  assign fifoAddr     = r_addr;
  assign memAddr      = r_addr[ADDRWIDTH-1:0];
  assign rdWrDisable  = r_dis;
  assign fifoLevel    = r_level;
  assign almostFlag   = r_almost;
  assign overUnderErr = r_err;

endmodule
